panel_cmd_sequencer: RTL and testbench

Front-panel command scheduler that feeds the CPU control block.
- Takes debounced button levels and hex keypad digits.
- Assembles a 16-bit user value from the digits.
- Arbitrates simultaneous button presses by fixed priority.
- Issues exactly one single-cycle command pulse at a time, with a hold-off gap so the monitor/NMI path can service each command.
- Sits between the panel debouncer/keypad scanner and the CPU control block's b_* / userInput / inputValid inputs.

---
 rtl/panel_pkg.sv | 48 ++++
 rtl/panel_cmd_sequencer_if.sv | 31 +++
 rtl/panel_cmd_sequencer_edge_detect.sv | 24 ++
 rtl/panel_cmd_sequencer.sv | 144 ++++++++++++++
 tb/tb_panel_cmd_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel command sequencer: command bit
// indices, FSM state encoding, command class masks and arbitration order.
package panel_pkg;

  localparam int NUM_CMDS = 12;

  localparam int CMD_STEP     = 0;
  localparam int CMD_RESET    = 1;
  localparam int CMD_RUNHALT  = 2;
  localparam int CMD_STOREINC = 3;
  localparam int CMD_IRQ      = 4;
  localparam int CMD_DEC      = 5;
  localparam int CMD_LOAD     = 6;
  localparam int CMD_TOA      = 7;
  localparam int CMD_TOSP     = 8;
  localparam int CMD_TOX      = 9;
  localparam int CMD_TOY      = 10;
  localparam int CMD_TOPC     = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } panel_state_e;

  function automatic logic [NUM_CMDS-1:0] cmd_bit(input int idx);
    logic [NUM_CMDS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Commands that take the entry buffer as their operand.
  localparam logic [NUM_CMDS-1:0] CONSUME_MASK =
    cmd_bit(CMD_LOAD) | cmd_bit(CMD_STOREINC) | cmd_bit(CMD_TOA) |
    cmd_bit(CMD_TOSP) | cmd_bit(CMD_TOX) | cmd_bit(CMD_TOY) | cmd_bit(CMD_TOPC);

  // Commands that touch memory and are only legal while the CPU is stopped.
  localparam logic [NUM_CMDS-1:0] MEM_MASK =
    cmd_bit(CMD_LOAD) | cmd_bit(CMD_DEC) | cmd_bit(CMD_STOREINC);

  // Arbitration order, highest priority first.
  localparam int PRIO_ORDER [NUM_CMDS] = '{
    CMD_RESET, CMD_RUNHALT, CMD_STEP, CMD_LOAD, CMD_DEC, CMD_STOREINC,
    CMD_TOA, CMD_TOSP, CMD_TOX, CMD_TOY, CMD_TOPC, CMD_IRQ
  };

endpackage

// File: rtl/panel_cmd_sequencer_if.sv
// Panel-side bundle between debouncer/keypad scanner, the sequencer and the
// CPU control block inputs.
interface panel_cmd_sequencer_if;

  // No back-pressure anywhere: key_valid/key_clear/cmd_pulse/dropped are
  // single-cycle strobes acted on in the cycle they are high; btn and
  // stopped are levels; user_input is a level qualified by input_valid,
  // which is only ever high in a cmd_pulse (or dropped) cycle.
  logic [panel_pkg::NUM_CMDS-1:0] btn;
  logic                           key_valid;
  logic [3:0]                     key_code;
  logic                           key_clear;
  logic                           stopped;
  logic [panel_pkg::NUM_CMDS-1:0] cmd_pulse;
  logic [15:0]                    user_input;
  logic                           input_valid;
  logic [2:0]                     digit_count;
  logic                           busy;
  logic                           dropped;

  modport master (
    output btn, key_valid, key_code, key_clear, stopped,
    input  cmd_pulse, user_input, input_valid, digit_count, busy, dropped
  );

  modport slave (
    input  btn, key_valid, key_code, key_clear, stopped,
    output cmd_pulse, user_input, input_valid, digit_count, busy, dropped
  );

endinterface

// File: rtl/panel_cmd_sequencer_edge_detect.sv
// Registered rising-edge detector for one debounced button level.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= level_i;
      rise_q <= level_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/panel_cmd_sequencer.sv
// Front-panel command scheduler: captures button edges, arbitrates them by
// fixed priority and issues one command pulse at a time with a hold-off gap.
module panel_cmd_sequencer
  import panel_pkg::*;
#(
  parameter int HOLDOFF = 16,
  parameter int HOLD_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  panel_cmd_sequencer_if.slave  pif,
  output panel_state_e          state_o
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam bit                SKIP_HOLD = (HOLDOFF <= 1);

  panel_state_e          state_q, state_d;
  logic [NUM_CMDS-1:0]   pending_q, pending_d;
  logic [3:0]            sel_q, sel_d;
  logic [HOLD_W-1:0]     cnt_q, cnt_d;
  logic [15:0]           buf_q, buf_d;
  logic [2:0]            dig_q, dig_d;

  logic [NUM_CMDS-1:0]   rise;
  logic [NUM_CMDS-1:0]   clr_mask;
  logic [NUM_CMDS-1:0]   pulse;
  logic [NUM_CMDS-1:0]   sel_bit;
  logic [3:0]            prio_sel;
  logic                  ivalid;
  logic                  drop;
  logic                  consume;

  for (genvar g = 0; g < NUM_CMDS; g++) begin : g_edge
    edge_detect u_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .level_i (pif.btn[g]),
      .rise_o  (rise[g])
    );
  end

  // Walk from lowest to highest priority so the highest pending one wins.
  always_comb begin
    prio_sel = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (pending_q[PRIO_ORDER[i]]) prio_sel = 4'(PRIO_ORDER[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    clr_mask = '0;
    pulse    = '0;
    ivalid   = 1'b0;
    drop     = 1'b0;
    consume  = 1'b0;
    sel_bit  = cmd_bit(int'(sel_q));
    unique case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          sel_d   = prio_sel;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        clr_mask = sel_bit;
        ivalid   = (dig_q != 3'd0);
        if (MEM_MASK[sel_q] && !pif.stopped) begin
          drop    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          pulse   = sel_bit;
          consume = CONSUME_MASK[sel_q] && ivalid;
          if (SKIP_HOLD) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = HOLD_LOAD;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Leave one cycle early: the IDLE cycle completes the idle gap.
        cnt_d = cnt_q - HOLD_ONE;
        if (cnt_q <= HOLD_ONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A fresh edge on the command being cleared re-arms it.
  assign pending_d = (pending_q & ~clr_mask) | rise;

  always_comb begin
    buf_d = buf_q;
    dig_d = dig_q;
    if (pif.key_clear) begin
      buf_d = '0;
      dig_d = '0;
    end else if (consume) begin
      if (pif.key_valid) begin
        buf_d = {12'd0, pif.key_code};
        dig_d = 3'd1;
      end else begin
        buf_d = '0;
        dig_d = '0;
      end
    end else if (pif.key_valid) begin
      buf_d = {buf_q[11:0], pif.key_code};
      dig_d = (dig_q == 3'd4) ? 3'd4 : dig_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      dig_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      dig_q     <= dig_d;
    end
  end

  assign pif.cmd_pulse   = pulse;
  assign pif.dropped     = drop;
  assign pif.input_valid = ivalid;
  assign pif.user_input  = buf_q;
  assign pif.digit_count = dig_q;
  assign pif.busy        = (state_q != ST_IDLE);
  assign state_o         = state_q;

endmodule

// File: tb/tb_panel_cmd_sequencer.sv
// Bench for panel_cmd_sequencer: directed scenarios plus randomized traffic
// checked against a timing-rule reference model.
module tb_panel_cmd_sequencer;
  import panel_pkg::*;

  localparam int HOLDOFF = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  panel_cmd_sequencer_if pif ();
  panel_state_e dut_state;

  panel_cmd_sequencer #(.HOLDOFF(HOLDOFF), .HOLD_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pif     (pif),
    .state_o (dut_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [11:0] exp_q[$];

  // Reference model: pending set, entry value and the cycle at which the
  // sequencer is next free to pick a command.
  logic [11:0] m_pend, m_rise_d, m_prev;
  bit          m_issue, m_drop, m_consume, m_idle;
  int          m_sel, m_free_at, m_cnt;
  logic [15:0] m_buf;
  logic [11:0] e_pulse;
  bit          e_ivalid, e_dropped, e_busy;

  function automatic logic [11:0] bit_of(input int c);
    logic [11:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic int top_cmd(input logic [11:0] p);
    int order [12];
    order = '{CMD_RESET, CMD_RUNHALT, CMD_STEP, CMD_LOAD, CMD_DEC, CMD_STOREINC,
              CMD_TOA, CMD_TOSP, CMD_TOX, CMD_TOY, CMD_TOPC, CMD_IRQ};
    for (int i = 0; i < 12; i++) if (p[order[i]]) return order[i];
    return 0;
  endfunction

  function automatic bit is_memory(input int c);
    return (c == CMD_LOAD) || (c == CMD_DEC) || (c == CMD_STOREINC);
  endfunction

  function automatic bit is_consuming(input int c);
    return (c == CMD_LOAD) || (c == CMD_STOREINC) || (c == CMD_TOA) ||
           (c == CMD_TOSP) || (c == CMD_TOX) || (c == CMD_TOY) || (c == CMD_TOPC);
  endfunction

  task automatic model_reset();
    m_pend = '0; m_rise_d = '0; m_prev = '0;
    m_issue = 0; m_drop = 0; m_consume = 0; m_idle = 1;
    m_sel = 0; m_free_at = 0; m_cnt = 0; m_buf = '0;
    e_pulse = '0; e_ivalid = 0; e_dropped = 0; e_busy = 0;
  endtask

  // Called at each rising edge with the inputs held over the previous cycle;
  // produces the expected outputs for the cycle that edge starts.
  task automatic model_step();
    bit start_issue;
    int next_sel;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    start_issue = m_idle && (m_pend != 0);
    next_sel    = top_cmd(m_pend);
    if (pif.key_clear) begin
      m_buf = '0; m_cnt = 0;
    end else if (m_consume) begin
      m_buf = pif.key_valid ? {12'd0, pif.key_code} : 16'd0;
      m_cnt = pif.key_valid ? 1 : 0;
    end else if (pif.key_valid) begin
      m_buf = (m_buf << 4) | {12'd0, pif.key_code};
      m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
    end
    if (m_issue) m_pend[m_sel] = 1'b0;
    m_pend   = m_pend | m_rise_d;
    m_rise_d = pif.btn & ~m_prev;
    m_prev   = pif.btn;
    m_issue  = start_issue;
    if (m_issue) begin
      m_sel     = next_sel;
      m_drop    = is_memory(m_sel) && !pif.stopped;
      m_free_at = m_drop ? cyc + 1 : cyc + HOLDOFF;
    end
    m_idle    = !m_issue && (cyc >= m_free_at);
    e_pulse   = (m_issue && !m_drop) ? bit_of(m_sel) : 12'd0;
    e_dropped = m_issue && m_drop;
    e_ivalid  = m_issue && (m_cnt != 0);
    e_busy    = !m_idle;
    m_consume = m_issue && !m_drop && is_consuming(m_sel) && e_ivalid;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    pif.key_valid = 1'b1;
    pif.key_code  = d;
    step();
    pif.key_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    settle(3);
    total++; if (pif.cmd_pulse !== 12'd0) begin bad++; $display("FAIL rst_pulse got=%h exp=0", pif.cmd_pulse); end
    total++; if (pif.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", pif.busy); end
    total++; if (pif.user_input !== 16'd0) begin bad++; $display("FAIL rst_user got=%h exp=0", pif.user_input); end
    total++; if (pif.digit_count !== 3'd0) begin bad++; $display("FAIL rst_digits got=%0d exp=0", pif.digit_count); end
    total++; if (pif.input_valid !== 1'b0) begin bad++; $display("FAIL rst_ivalid got=%b exp=0", pif.input_valid); end
    total++; if (pif.dropped !== 1'b0) begin bad++; $display("FAIL rst_dropped got=%b exp=0", pif.dropped); end
    rst_n = 1'b1;
    settle(2);
    total++; if (pif.busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b exp=0", pif.busy); end
  endtask

  task automatic test_load_entry();
    int lat;
    pif.stopped = 1'b1;
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    total++; if (pif.digit_count !== 3'd4) begin bad++; $display("FAIL load_digits got=%0d exp=4", pif.digit_count); end
    pif.btn[CMD_LOAD] = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) pif.btn[CMD_LOAD] = 1'b0;
      if (pif.cmd_pulse != 12'd0) begin lat = i; break; end
    end
    total++; if (lat != 3) begin bad++; $display("FAIL load_latency got=%0d exp=3", lat); end
    total++; if (pif.cmd_pulse !== bit_of(CMD_LOAD)) begin bad++; $display("FAIL load_pulse got=%h exp=%h", pif.cmd_pulse, bit_of(CMD_LOAD)); end
    total++; if (pif.user_input !== 16'h1234) begin bad++; $display("FAIL load_user got=%h exp=1234", pif.user_input); end
    total++; if (pif.input_valid !== 1'b1) begin bad++; $display("FAIL load_ivalid got=%b exp=1", pif.input_valid); end
    step();
    total++; if (pif.cmd_pulse !== 12'd0) begin bad++; $display("FAIL load_single got=%h exp=0", pif.cmd_pulse); end
    total++; if (pif.digit_count !== 3'd0) begin bad++; $display("FAIL load_clr_digits got=%0d exp=0", pif.digit_count); end
    total++; if (pif.user_input !== 16'd0) begin bad++; $display("FAIL load_clr_user got=%h exp=0", pif.user_input); end
    settle(HOLDOFF + 2);
  endtask

  task automatic test_five_digits();
    key(4'hA); key(4'hB); key(4'hC); key(4'hD); key(4'hE);
    total++; if (pif.user_input !== 16'hBCDE) begin bad++; $display("FAIL five_user got=%h exp=bcde", pif.user_input); end
    total++; if (pif.digit_count !== 3'd4) begin bad++; $display("FAIL five_digits got=%0d exp=4", pif.digit_count); end
    pif.key_clear = 1'b1;
    key(4'h7);
    pif.key_clear = 1'b0;
    total++; if (pif.user_input !== 16'd0) begin bad++; $display("FAIL clear_wins_user got=%h exp=0", pif.user_input); end
    total++; if (pif.digit_count !== 3'd0) begin bad++; $display("FAIL clear_wins_digits got=%0d exp=0", pif.digit_count); end
  endtask

  task automatic test_simultaneous();
    int t_first, t_second;
    logic [11:0] exp_w;
    key(4'h4); key(4'h2);
    pif.btn[CMD_STEP] = 1'b1;
    pif.btn[CMD_TOX]  = 1'b1;
    exp_q.push_back(bit_of(CMD_STEP));
    exp_q.push_back(bit_of(CMD_TOX));
    t_first = -1; t_second = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      pif.key_valid = 1'b0;
      if (i == 1) pif.btn = '0;
      if (i == t_second + 1) begin
        total++; if (pif.user_input !== 16'h0005) begin bad++; $display("FAIL clr_key_user got=%h exp=0005", pif.user_input); end
        total++; if (pif.digit_count !== 3'd1) begin bad++; $display("FAIL clr_key_digits got=%0d exp=1", pif.digit_count); end
        break;
      end
      if (pif.cmd_pulse != 12'd0) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 12'd0;
        total++; if (pif.cmd_pulse !== exp_w) begin bad++; $display("FAIL order_pulse got=%h exp=%h", pif.cmd_pulse, exp_w); end
        if (t_first < 0) begin
          t_first = i;
        end else begin
          t_second = i;
          total++; if (pif.input_valid !== 1'b1) begin bad++; $display("FAIL tox_ivalid got=%b exp=1", pif.input_valid); end
          total++; if (pif.user_input !== 16'h0042) begin bad++; $display("FAIL tox_user got=%h exp=0042", pif.user_input); end
          pif.key_valid = 1'b1;
          pif.key_code  = 4'h5;
        end
      end
    end
    total++; if (t_first != 3) begin bad++; $display("FAIL step_latency got=%0d exp=3", t_first); end
    total++; if (t_second - t_first != HOLDOFF + 1) begin bad++; $display("FAIL pulse_gap got=%0d exp=%0d", t_second - t_first, HOLDOFF + 1); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL order_left got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
    pif.key_clear = 1'b1; step(); pif.key_clear = 1'b0;
    settle(HOLDOFF + 2);
  endtask

  task automatic test_drop();
    int lat;
    pif.stopped = 1'b0;
    step();
    key(4'h7);
    pif.btn[CMD_STOREINC] = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) pif.btn = '0;
      if (pif.dropped === 1'b1 || pif.cmd_pulse != 12'd0) begin lat = i; break; end
    end
    total++; if (lat != 3) begin bad++; $display("FAIL drop_latency got=%0d exp=3", lat); end
    total++; if (pif.dropped !== 1'b1) begin bad++; $display("FAIL drop_flag got=%b exp=1", pif.dropped); end
    total++; if (pif.cmd_pulse !== 12'd0) begin bad++; $display("FAIL drop_pulse got=%h exp=0", pif.cmd_pulse); end
    total++; if (pif.input_valid !== 1'b1) begin bad++; $display("FAIL drop_ivalid got=%b exp=1", pif.input_valid); end
    step();
    total++; if (pif.dropped !== 1'b0) begin bad++; $display("FAIL drop_single got=%b exp=0", pif.dropped); end
    total++; if (pif.busy !== 1'b0) begin bad++; $display("FAIL drop_busy got=%b exp=0", pif.busy); end
    total++; if (pif.user_input !== 16'h0007) begin bad++; $display("FAIL drop_keep got=%h exp=0007", pif.user_input); end
    pif.stopped = 1'b1;
    pif.key_clear = 1'b1; step(); pif.key_clear = 1'b0;
    settle(3);
  endtask

  task automatic test_runhalt_merge();
    int n_run, n_other, t2;
    n_run = 0; n_other = 0; t2 = -1;
    pif.btn[CMD_RUNHALT] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (i == 1 || i == 7 || i == 10) pif.btn[CMD_RUNHALT] = 1'b0;
      if (i == 6 || i == 9) pif.btn[CMD_RUNHALT] = 1'b1;
      if (pif.cmd_pulse == bit_of(CMD_RUNHALT)) begin
        n_run++;
        if (n_run == 2) t2 = i;
      end else if (pif.cmd_pulse != 12'd0) begin
        n_other++;
      end
    end
    total++; if (n_run != 2) begin bad++; $display("FAIL merge_count got=%0d exp=2", n_run); end
    total++; if (n_other != 0) begin bad++; $display("FAIL merge_other got=%0d exp=0", n_other); end
    total++; if (t2 != 3 + HOLDOFF + 1) begin bad++; $display("FAIL merge_time got=%0d exp=%0d", t2, 3 + HOLDOFF + 1); end
  endtask

  task automatic test_reset_mid_hold();
    int n_pulse;
    key(4'h9);
    pif.btn[CMD_STEP] = 1'b1;
    step();
    pif.btn = '0;
    settle(4);
    pif.btn[CMD_TOPC] = 1'b1;
    step();
    pif.btn = '0;
    settle(3);
    total++; if (pif.busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b exp=1", pif.busy); end
    rst_n = 1'b0;
    #1;
    total++; if (pif.busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", pif.busy); end
    total++; if (pif.user_input !== 16'd0) begin bad++; $display("FAIL arst_user got=%h exp=0", pif.user_input); end
    total++; if (pif.digit_count !== 3'd0) begin bad++; $display("FAIL arst_digits got=%0d exp=0", pif.digit_count); end
    total++; if (pif.cmd_pulse !== 12'd0) begin bad++; $display("FAIL arst_pulse got=%h exp=0", pif.cmd_pulse); end
    settle(2);
    rst_n = 1'b1;
    n_pulse = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pif.cmd_pulse != 12'd0) n_pulse++;
    end
    total++; if (n_pulse != 0) begin bad++; $display("FAIL arst_lost got=%0d exp=0", n_pulse); end
  endtask

  task automatic test_random();
    for (int ph = 0; ph < 2; ph++) begin
      pif.btn = '0; pif.key_valid = 1'b0; pif.key_clear = 1'b0;
      settle(3 * (HOLDOFF + 2));
      pif.stopped = (ph == 0);
      step();
      for (int i = 0; i < 400; i++) begin
        step();
        total++; if (pif.cmd_pulse !== e_pulse) begin bad++; $display("FAIL rnd_pulse cyc=%0d got=%h exp=%h", cyc, pif.cmd_pulse, e_pulse); end
        total++; if (pif.dropped !== e_dropped) begin bad++; $display("FAIL rnd_dropped cyc=%0d got=%b exp=%b", cyc, pif.dropped, e_dropped); end
        total++; if (pif.input_valid !== e_ivalid) begin bad++; $display("FAIL rnd_ivalid cyc=%0d got=%b exp=%b", cyc, pif.input_valid, e_ivalid); end
        total++; if (pif.busy !== e_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, pif.busy, e_busy); end
        total++; if (pif.user_input !== m_buf) begin bad++; $display("FAIL rnd_user cyc=%0d got=%h exp=%h", cyc, pif.user_input, m_buf); end
        total++; if (pif.digit_count !== 3'(m_cnt)) begin bad++; $display("FAIL rnd_digits cyc=%0d got=%0d exp=%0d", cyc, pif.digit_count, m_cnt); end
        if ($urandom_range(0, 2) == 0) pif.btn[$urandom_range(0, 11)] ^= 1'b1;
        pif.key_valid = ($urandom_range(0, 3) == 0);
        pif.key_code  = 4'($urandom_range(0, 15));
        pif.key_clear = ($urandom_range(0, 19) == 0);
      end
    end
    pif.btn = '0; pif.key_valid = 1'b0; pif.key_clear = 1'b0;
  endtask

  initial begin
    pif.btn = '0; pif.key_valid = 1'b0; pif.key_code = 4'h0;
    pif.key_clear = 1'b0; pif.stopped = 1'b1;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_load_entry();
    test_five_digits();
    test_simultaneous();
    test_drop();
    test_runhalt_merge();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
